// File: rtl/booth_mul_seq_if.sv
// Handshake bundle between the EXE-stage MUL path and the Booth multiplier.
interface booth_mul_seq_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic        busy;

  modport master (
    output flush, in_valid, in_signed, in_src1, in_src2, out_ready,
    input  in_ready, out_valid, out_prod, busy
  );

  modport slave (
    input  flush, in_valid, in_signed, in_src1, in_src2, out_ready,
    output in_ready, out_valid, out_prod, busy
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: PP_PER_CYCLE Booth triplets are decoded
// and accumulated into a 66-bit register each BUSY cycle; the 64-bit product
// is held in DONE until the consumer takes it. Flush cancels any op.
module booth_mul_seq #(
  parameter int PP_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  booth_mul_seq_if.slave  bus
);
  localparam int NTRIP = 17;
  localparam int NITER = (NTRIP + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int SH    = 2 * PP_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [65:0] xs_q, xs_d;    // multiplicand, sign-extended, pre-shifted to current triplet weight
  logic [34:0] ys_q, ys_d;    // Booth scan vector, shifted right as triplets are consumed
  logic [65:0] acc_q, acc_d;
  logic [4:0]  iter_q, iter_d;

  logic [32:0] x33, y33;
  logic [65:0] acc_nx;
  logic        accept;

  assign x33    = {bus.in_signed & bus.in_src1[31], bus.in_src1};
  assign y33    = {bus.in_signed & bus.in_src2[31], bus.in_src2};
  assign bus.in_ready  = (state_q == IDLE) & ~bus.flush & ~reset;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_prod  = acc_q[63:0];

  // Booth decode of this cycle's triplets; triplets past index 16 add nothing
  always_comb begin
    logic [2:0]  t;
    logic [65:0] m, term;
    int          idx;
    acc_nx = acc_q;
    for (int k = 0; k < PP_PER_CYCLE; k++) begin
      t    = ys_q[2*k +: 3];
      m    = xs_q << (2*k);
      idx  = int'(iter_q) * PP_PER_CYCLE + k;
      term = '0;
      case (t)
        3'b001, 3'b010: term = m;
        3'b011:         term = m << 1;
        3'b101, 3'b110: term = ~m + 66'd1;
        3'b100:         term = ~(m << 1) + 66'd1;
        default:        term = '0;
      endcase
      if (idx >= NTRIP) term = '0;
      acc_nx = acc_nx + term;
    end
  end

  // Next-state: accept in IDLE, iterate in BUSY, hold in DONE; flush overrides all
  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: if (accept) begin
        xs_d    = {{33{x33[32]}}, x33};
        ys_d    = {y33[32], y33, 1'b0};
        acc_d   = '0;
        iter_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        acc_d  = acc_nx;
        xs_d   = xs_q << SH;
        ys_d   = ys_q >> SH;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'(NITER - 1)) state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      acc_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: PP_PER_CYCLE=1 main instance plus a
// PP_PER_CYCLE=2 instance for the latency variant.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  booth_mul_seq_if bus1();
  booth_mul_seq_if bus2();

  booth_mul_seq #(.PP_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  booth_mul_seq #(.PP_PER_CYCLE(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full op on dut1: accept, measure latency, check product, hand off
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int exp_lat, input string name);
    int cnt;
    cnt = 0;
    while (!bus1.in_ready && cnt < 40) begin tick(); cnt++; end
    bus1.in_valid = 1'b1; bus1.in_signed = sgn; bus1.in_src1 = a; bus1.in_src2 = b;
    tick();
    // scramble operands after acceptance; they must be ignored
    bus1.in_valid = 1'b0; bus1.in_signed = ~sgn; bus1.in_src1 = ~a; bus1.in_src2 = ~b;
    cnt = 1;
    while (!bus1.out_valid && cnt < 40) begin tick(); cnt++; end
    checks++;
    if (cnt !== exp_lat) begin
      failures++; $display("FAIL %s latency: got T+%0d want T+%0d", name, cnt, exp_lat);
    end
    checks++;
    if (bus1.out_prod !== exp) begin
      failures++; $display("FAIL %s product: got %h want %h", name, bus1.out_prod, exp);
    end
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1) begin
      failures++; $display("FAIL %s handoff: out_valid=%b in_ready=%b want 0/1",
                           name, bus1.out_valid, bus1.in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.out_prod !== 64'h0 || bus1.busy !== 1'b0 ||
        bus1.in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_state: ov=%b prod=%h busy=%b ir=%b want 0/0/0/0",
                           bus1.out_valid, bus1.out_prod, bus1.busy, bus1.in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus1.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release in_ready: got %b want 1", bus1.in_ready);
    end
    tick();
  endtask

  task automatic test_unsigned();
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 18, "u_max");
    run_op(1'b0, 32'h8000_0000, 32'h0000_0001, 64'h00000000_80000000, 18, "u_msb_x1");
  endtask

  task automatic test_signed();
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 18, "s_min_min");
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000000_00000001, 18, "s_m1_m1");
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFFFFFF_80000000, 18, "s_min_x1");
    run_op(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFFFFFF_00000001, 18, "s_max_max");
    run_op(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC0000000_80000000, 18, "s_min_max");
  endtask

  task automatic test_back_to_back();
    int cnt;
    bus1.in_valid = 1'b1; bus1.in_signed = 1'b1;
    bus1.in_src1 = 32'hFFFF_FFFE; bus1.in_src2 = 32'h0000_0003;
    tick();
    bus1.in_valid = 1'b0;
    cnt = 1;
    while (!bus1.out_valid && cnt < 40) begin tick(); cnt++; end
    checks++;
    if (cnt !== 18) begin
      failures++; $display("FAIL bp latency: got T+%0d want T+18", cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus1.out_valid !== 1'b1 || bus1.out_prod !== 64'hFFFFFFFF_FFFFFFFA ||
          bus1.in_ready !== 1'b0 || bus1.busy !== 1'b1) begin
        failures++; $display("FAIL bp hold[%0d]: ov=%b prod=%h ir=%b busy=%b want 1/FFFFFFFFFFFFFFFA/0/1",
                             i, bus1.out_valid, bus1.out_prod, bus1.in_ready, bus1.busy);
      end
    end
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
      failures++; $display("FAIL bp release: ir=%b ov=%b want 1/0", bus1.in_ready, bus1.out_valid);
    end
    run_op(1'b0, 32'd7, 32'd6, 64'h2A, 18, "b2b_7x6");
  endtask

  task automatic test_flush();
    logic seen;
    bus1.in_valid = 1'b1; bus1.in_signed = 1'b0; bus1.in_src1 = 32'd5; bus1.in_src2 = 32'd5;
    tick();
    bus1.in_valid = 1'b0;
    repeat (7) tick();  // now in 8th BUSY cycle
    bus1.flush = 1'b1;
    bus1.in_valid = 1'b1; bus1.in_src1 = 32'd9; bus1.in_src2 = 32'd9;
    #1;
    checks++;
    if (bus1.in_ready !== 1'b0 || bus1.busy !== 1'b1) begin
      failures++; $display("FAIL flush in_ready/busy during flush: ir=%b busy=%b want 0/1",
                           bus1.in_ready, bus1.busy);
    end
    @(posedge clk); #1;
    bus1.flush = 1'b0; bus1.in_valid = 1'b0;
    #1;
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.busy !== 1'b0) begin
      failures++; $display("FAIL flush recover: ir=%b busy=%b want 1/0", bus1.in_ready, bus1.busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus1.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL flush no_result: out_valid seen=%b want 0", seen);
    end
    // op presented together with flush in IDLE must not be accepted
    bus1.flush = 1'b1; bus1.in_valid = 1'b1;
    tick();
    bus1.flush = 1'b0; bus1.in_valid = 1'b0;
    #1;
    checks++;
    if (bus1.busy !== 1'b0) begin
      failures++; $display("FAIL flush idle_accept: busy=%b want 0", bus1.busy);
    end
    tick();
    run_op(1'b1, 32'd3, 32'hFFFF_FFFB, 64'hFFFFFFFF_FFFFFFF1, 18, "post_flush_3xm5");
  endtask

  task automatic test_async_reset();
    int cnt;
    bus1.in_valid = 1'b1; bus1.in_signed = 1'b1;
    bus1.in_src1 = 32'h7FFF_FFFF; bus1.in_src2 = 32'h7FFF_FFFF;
    tick();
    bus1.in_valid = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus1.busy !== 1'b0 || bus1.out_valid !== 1'b0 || bus1.out_prod !== 64'h0) begin
      failures++; $display("FAIL areset busy: busy=%b ov=%b prod=%h want 0/0/0",
                           bus1.busy, bus1.out_valid, bus1.out_prod);
    end
    reset = 1'b0;
    tick();
    // reset while holding a finished result
    bus1.in_valid = 1'b1; bus1.in_signed = 1'b0; bus1.in_src1 = 32'd7; bus1.in_src2 = 32'd6;
    tick();
    bus1.in_valid = 1'b0;
    cnt = 1;
    while (!bus1.out_valid && cnt < 40) begin tick(); cnt++; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.out_prod !== 64'h0 || bus1.busy !== 1'b0) begin
      failures++; $display("FAIL areset done: ov=%b prod=%h busy=%b want 0/0/0",
                           bus1.out_valid, bus1.out_prod, bus1.busy);
    end
    reset = 1'b0;
    tick();
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 18, "post_reset_u_max");
  endtask

  task automatic test_pp2();
    int cnt;
    bus2.in_valid = 1'b1; bus2.in_signed = 1'b0;
    bus2.in_src1 = 32'hFFFF_FFFF; bus2.in_src2 = 32'hFFFF_FFFF;
    tick();
    bus2.in_valid = 1'b0; bus2.in_src1 = '0; bus2.in_src2 = '0;
    cnt = 1;
    while (!bus2.out_valid && cnt < 40) begin tick(); cnt++; end
    checks++;
    if (cnt !== 10) begin
      failures++; $display("FAIL pp2 latency: got T+%0d want T+10", cnt);
    end
    checks++;
    if (bus2.out_prod !== 64'hFFFFFFFE_00000001) begin
      failures++; $display("FAIL pp2 product: got %h want FFFFFFFE00000001", bus2.out_prod);
    end
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;
    // odd triplet count: signed min*min exercises the gated 18th triplet slot
    bus2.in_valid = 1'b1; bus2.in_signed = 1'b1;
    bus2.in_src1 = 32'h8000_0000; bus2.in_src2 = 32'h8000_0000;
    tick();
    bus2.in_valid = 1'b0;
    cnt = 1;
    while (!bus2.out_valid && cnt < 40) begin tick(); cnt++; end
    checks++;
    if (bus2.out_prod !== 64'h40000000_00000000 || cnt !== 10) begin
      failures++; $display("FAIL pp2 s_min_min: got %h at T+%0d want 4000000000000000 at T+10",
                           bus2.out_prod, cnt);
    end
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.in_signed = 1'b0;
    bus1.in_src1 = '0; bus1.in_src2 = '0; bus1.out_ready = 1'b0;
    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.in_signed = 1'b0;
    bus2.in_src1 = '0; bus2.in_src2 = '0; bus2.out_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_pp2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
